vector_read_module: RTL and testbench

Sequential memory-to-register gather engine for the vector datapath, complementary to the vector write path. On a start pulse it issues either one scalar read or I consecutive vector-item reads, starting at a base address, to a synchronous data memory. It reassembles the returned words into a packed vector or a scalar result, then pulses `finished`. It sits between the decode/control stage (load instructions) and the vector/scalar register files.

---
 rtl/vector_read_pkg.sv | 22 ++
 rtl/vector_read_module_if.sv | 14 +
 rtl/read_latency_pipe.sv | 35 +++
 rtl/vector_read_module.sv | 98 +++++++++
 tb/tb_vector_read_module.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_read_pkg.sv
// Shared types and default sizes for the vector load/store datapath.
package vector_read_pkg;

   localparam int I_DEF = 20;
   localparam int L_DEF = 32;
   localparam int A_DEF = 10;
   localparam int IDX_W = $clog2(I_DEF);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } read_state_t;

   // Travels alongside an outstanding read so the returning word lands in the right slot.
   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] index;
   } tag_t;

endpackage

// File: rtl/vector_read_module_if.sv
// Synchronous data-memory read port: the gather engine drives the master side.
interface vector_read_module_if
   import vector_read_pkg::*;
#(
   parameter int L = L_DEF,
   parameter int A = A_DEF
);
   logic         read_en;
   logic [A-1:0] read_address;
   logic [L-1:0] read_data;

   modport master (output read_en, output read_address, input read_data);
   modport slave  (input read_en, input read_address, output read_data);
endinterface

// File: rtl/read_latency_pipe.sv
// Delay line for read tags; a tag leaves exactly RD_LAT cycles after it was issued,
// in step with the memory's returned word.
module read_latency_pipe
   import vector_read_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out,
   output logic pending
);

   tag_t stage [RD_LAT];

   // Shift tags one stage per cycle; reset drops every in-flight tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[RD_LAT-1];

   // Valid tags still behind the output stage; the output one is consumed this cycle.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < RD_LAT - 1; i++) pending = pending | stage[i].valid;
   end

endmodule

// File: rtl/vector_read_module.sv
// Gather engine: issues one scalar or I consecutive item reads from a base address
// and reassembles the returned words into the vector or scalar result register.
module vector_read_module
   import vector_read_pkg::*;
#(
   parameter int I      = I_DEF,
   parameter int L      = L_DEF,
   parameter int A      = A_DEF,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 op_type,
   input  logic [A-1:0]         base_address,
   vector_read_module_if.master mem_bus,
   output logic [I-1:0][L-1:0]  vector_data,
   output logic [L-1:0]         scalar_data,
   output logic                 busy,
   output logic                 finished
);

   read_state_t      state, state_nxt;
   logic             op_vec;
   logic [A-1:0]     base_q;
   logic [IDX_W-1:0] issue_cnt;
   logic [IDX_W-1:0] last_idx;
   logic             accept;
   tag_t             tag_in, tag_out;
   logic             pending;

   // A new request is only taken when nothing is in flight.
   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign last_idx = op_vec ? IDX_W'(I - 1) : '0;

   read_latency_pipe #(.RD_LAT(RD_LAT)) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out),
      .pending (pending)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: issue N requests, drain the tag pipe, then a one-cycle DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   if (issue_cnt == last_idx) state_nxt = DRAIN;
         DRAIN:   if (!pending) state_nxt = DONE;
         DONE:    state_nxt = start ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latches and issue counter; start while busy leaves them alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_vec    <= 1'b0;
         base_q    <= '0;
         issue_cnt <= '0;
      end else if (accept) begin
         op_vec    <= op_type;
         base_q    <= base_address;
         issue_cnt <= '0;
      end else if (state == ISSUE) begin
         issue_cnt <= issue_cnt + 1'b1;
      end
   end

   // Read strobe, wrapping address, status outputs and the tag launched with each read.
   always_comb begin
      mem_bus.read_en      = (state == ISSUE);
      mem_bus.read_address = '0;
      if (state == ISSUE) mem_bus.read_address = base_q + A'(issue_cnt);
      busy     = (state == ISSUE) || (state == DRAIN);
      finished = (state == DONE);
      tag_in   = '{valid: (state == ISSUE), index: issue_cnt};
   end

   // Capture returned words into the slot named by the emerging tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         vector_data <= '0;
         scalar_data <= '0;
      end else if (tag_out.valid) begin
         if (op_vec) vector_data[tag_out.index] <= mem_bus.read_data;
         else        scalar_data <= mem_bus.read_data;
      end
   end

endmodule

// File: tb/tb_vector_read_module.sv
// Bench: two engines (read latency 1 and 3) share one memory image; a scoreboard
// of expected reads and results is filled at issue time and drained by a monitor.
module tb_vector_read_module;

   localparam int I  = 20;
   localparam int L  = 32;
   localparam int A  = 10;
   localparam int NI = 2;

   typedef struct {
      int           g;
      logic [A-1:0] addr;
      int           cyc;
   } addr_e_t;

   typedef struct {
      int                  g;
      bit                  op;
      logic [I-1:0][L-1:0] vec;
      logic [L-1:0]        sc;
      int                  cyc;
   } res_e_t;

   logic                clk;
   logic                rst;
   logic                start_v [NI];
   logic                op_type;
   logic [A-1:0]        base_address;
   logic [L-1:0]        mem [1 << A];
   logic                re  [NI];
   logic [A-1:0]        ra  [NI];
   logic [I-1:0][L-1:0] vd  [NI];
   logic [L-1:0]        sd  [NI];
   logic                bz  [NI];
   logic                fin [NI];

   addr_e_t addr_q [$];
   res_e_t  res_q  [$];
   int      cyc       = 0;
   int      checks    = 0;
   int      passes    = 0;
   bit      rst_last  = 1'b0;
   bit      stim_done = 1'b0;

   logic [I-1:0][L-1:0] mvec [NI];
   logic [L-1:0]        msc  [NI];

   function automatic int lat_of(input int g);
      return (g == 0) ? 1 : 3;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < NI; g++) begin : inst
         localparam int LAT = (g == 0) ? 1 : 3;
         vector_read_module_if #(.L(L), .A(A)) bus ();
         logic [L-1:0] dpipe [LAT];

         vector_read_module #(.I(I), .L(L), .A(A), .RD_LAT(LAT)) dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start_v[g]),
            .op_type      (op_type),
            .base_address (base_address),
            .mem_bus      (bus),
            .vector_data  (vd[g]),
            .scalar_data  (sd[g]),
            .busy         (bz[g]),
            .finished     (fin[g])
         );

         // Synchronous memory: word appears LAT cycles after its strobe, junk otherwise.
         always @(posedge clk) begin
            dpipe[0] <= bus.read_en ? mem[bus.read_address] : $urandom;
            for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
         end
         assign bus.read_data = dpipe[LAT-1];
         assign re[g] = bus.read_en;
         assign ra[g] = bus.read_address;
      end
   endgenerate

   task automatic chk(input bit ok, input string name, input logic [I*L-1:0] act, input logic [I*L-1:0] exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // Monitor: one pass per falling edge.
   initial begin
      addr_e_t e;
      res_e_t  r;
      for (int g = 0; g < NI; g++) begin
         mvec[g] = '0;
         msc[g]  = '0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_last) begin
            for (int g = 0; g < NI; g++) begin
               mvec[g] = '0;
               msc[g]  = '0;
               chk({re[g], bz[g], fin[g], ra[g]} === '0, $sformatf("inst%0d reset_ctl cyc%0d", g, cyc),
                   {re[g], bz[g], fin[g], ra[g]}, '0);
               chk(vd[g] === '0 && sd[g] === '0, $sformatf("inst%0d reset_results cyc%0d", g, cyc),
                   {vd[g][19:0], sd[g]}, '0);
            end
         end
         for (int g = 0; g < NI; g++) begin
            if (re[g] === 1'b1) begin
               if (addr_q.size() == 0) begin
                  chk(1'b0, $sformatf("inst%0d unexpected_read_en cyc%0d", g, cyc), ra[g], '0);
               end else begin
                  e = addr_q.pop_front();
                  chk(e.g == g && ra[g] === e.addr && cyc == e.cyc,
                      $sformatf("inst%0d read_address cyc%0d (inst,cycle,addr)", g, cyc),
                      {g, cyc, ra[g]}, {e.g, e.cyc, e.addr});
                  chk(bz[g] === 1'b1, $sformatf("inst%0d busy_during_issue cyc%0d", g, cyc), bz[g], 1);
               end
            end
            if (fin[g] === 1'b1) begin
               if (res_q.size() == 0) begin
                  chk(1'b0, $sformatf("inst%0d unexpected_finished cyc%0d", g, cyc), cyc, '0);
               end else begin
                  r = res_q.pop_front();
                  chk(r.g == g && cyc == r.cyc, $sformatf("inst%0d finished_cycle (inst,cycle)", g),
                      {g, cyc}, {r.g, r.cyc});
                  if (r.op) mvec[g] = r.vec;
                  else      msc[g]  = r.sc;
                  chk(vd[g] === mvec[g], $sformatf("inst%0d vector_data cyc%0d", g, cyc), vd[g], mvec[g]);
                  chk(sd[g] === msc[g], $sformatf("inst%0d scalar_data cyc%0d", g, cyc), sd[g], msc[g]);
                  chk(bz[g] === 1'b0, $sformatf("inst%0d busy_at_finished cyc%0d", g, cyc), bz[g], 0);
               end
            end else if (bz[g] === 1'b0) begin
               chk(vd[g] === mvec[g], $sformatf("inst%0d vector_hold cyc%0d", g, cyc), vd[g], mvec[g]);
               chk(sd[g] === msc[g], $sformatf("inst%0d scalar_hold cyc%0d", g, cyc), sd[g], msc[g]);
            end
         end
         if (rst === 1'b1) begin
            addr_q.delete();
            res_q.delete();
         end
         rst_last = (rst === 1'b1);
         if (stim_done) begin
            chk(addr_q.size() == 0 && res_q.size() == 0, "scoreboard_drained",
                {addr_q.size(), res_q.size()}, '0);
            $display("%0d/%0d checks passed", passes, checks);
            $finish;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1 in a cycle where engine g is idle or finishing.
   task automatic issue(input int g, input bit op, input logic [A-1:0] base);
      int     n;
      int     c0;
      res_e_t r;
      n      = op ? I : 1;
      c0     = cyc + 1;
      r.g    = g;
      r.op   = op;
      r.vec  = '0;
      r.sc   = '0;
      r.cyc  = c0 + n + lat_of(g) + 1;
      for (int k = 0; k < n; k++) begin
         logic [A-1:0] a;
         a = base + A'(k);
         addr_q.push_back('{g, a, c0 + 1 + k});
         if (op) r.vec[k] = mem[a];
         else    r.sc     = mem[a];
      end
      res_q.push_back(r);
      op_type      = op;
      base_address = base;
      start_v[g]   = 1'b1;
      step(1);
      start_v[g]   = 1'b0;
   endtask

   task automatic wait_fin(input int g);
      for (int t = 0; t < 100; t++) begin
         if (fin[g] === 1'b1) return;
         step(1);
      end
      $display("FAIL inst%0d wait_finished: no finished pulse within 100 cycles", g);
      $fatal(1);
   endtask

   task automatic mem_random();
      for (int a = 0; a < (1 << A); a++) mem[a] = $urandom;
   endtask

   task automatic pulse_ignored(input int g, input bit op, input logic [A-1:0] base);
      op_type      = op;
      base_address = base;
      start_v[g]   = 1'b1;
      step(1);
      start_v[g]   = 1'b0;
   endtask

   // Stimulus.
   initial begin
      rst          = 1'b1;
      start_v[0]   = 1'b0;
      start_v[1]   = 1'b0;
      op_type      = 1'b0;
      base_address = '0;
      for (int a = 0; a < (1 << A); a++) mem[a] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      step(1);

      for (int a = 0; a < (1 << A); a++) mem[a] = L'(a * 3);
      issue(0, 1'b1, 10'h010);
      wait_fin(0);
      step(1);

      mem[10'h3FF] = 32'hDEADBEEF;
      issue(0, 1'b0, 10'h3FF);
      wait_fin(0);
      step(1);

      mem_random();
      issue(0, 1'b1, 10'h3FA);
      wait_fin(0);
      step(2);

      issue(0, 1'b1, 10'h100);
      step(3);
      pulse_ignored(0, 1'b0, 10'h200);
      step(5);
      pulse_ignored(0, 1'b1, 10'h2AA);
      wait_fin(0);
      issue(0, 1'b0, 10'h055);
      wait_fin(0);
      step(2);

      issue(0, 1'b1, 10'h020);
      step(9);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(3);
      issue(0, 1'b1, 10'h030);
      wait_fin(0);
      step(2);

      issue(1, 1'b1, 10'h040);
      step(9);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(2);
      issue(1, 1'b1, 10'h060);
      step(21);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(5);

      mem_random();
      issue(1, 1'b1, 10'h3F0);
      wait_fin(1);
      issue(1, 1'b0, 10'h123);
      wait_fin(1);
      step(2);

      for (int t = 0; t < 14; t++) begin
         int g;
         g = $urandom_range(0, 1);
         mem_random();
         issue(g, 1'($urandom_range(0, 1)), A'($urandom));
         wait_fin(g);
         if ($urandom_range(0, 1) == 1) begin
            mem_random();
            issue(g, 1'($urandom_range(0, 1)), A'($urandom));
            wait_fin(g);
         end
         step($urandom_range(1, 3));
      end

      step(3);
      stim_done = 1'b1;
   end

endmodule
